counter_seq_ctrl: RTL and testbench
===================================

// Module: counter_seq_ctrl
// PURPOSE
//  Sequencing controller for the N-bit asynchronous up/down counter (ports clk, rst, enable, up_count, down_count, q).
//  Drives enable/up_count/down_count and watches q to run one-shot up, one-shot down,
//  ping-pong (0<->limit) and continuous-up sequences. Reports busy, terminal-count and done.
//  Sits beside the counter. Integration: counter.rst = ~rst_n, counter.q -> cnt_q.
// PARAMETERS
//  N  4  counter width; must equal the controlled counter's N
// PORTS
//  clk        in   1  single clock, rising edge, shared with the counter
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  start request; sampled only in IDLE
//  stop       in   1  abort; returns a running sequence to IDLE
//  hold       in   1  pause; freezes state and counter while high
//  mode       in   2  00 ONESHOT_UP, 01 ONESHOT_DN, 10 PINGPONG, 11 CONT_UP; sampled with start
//  limit      in   N  upper target; sampled with start
//  cnt_q      in   N  counter q feedback
//  cnt_en     out  1  to counter enable (combinational)
//  cnt_up     out  1  to counter up_count (combinational)
//  cnt_dn     out  1  to counter down_count (combinational)
//  busy       out  1  high in RUN_UP/RUN_DN
//  tc         out  1  registered 1-cycle terminal-count pulse
//  done       out  1  1-cycle pulse, high in DONE state
// BEHAVIOUR
//  Reset: state=IDLE, mode_r=00, limit_r=0, tc=0. Outputs cnt_en/cnt_up/cnt_dn/busy/done=0.
//  States: IDLE, RUN_UP, RUN_DN, DONE. Binary encoded.
//  target = limit_r in RUN_UP, 0 in RUN_DN; at_tgt = (cnt_q==target).
//  cnt_up = (state==RUN_UP); cnt_dn = (state==RUN_DN); never both high; all 0 in IDLE/DONE.
//  cnt_en = busy & ~hold & ~stop & (~at_tgt | mode_r==CONT_UP).
//  Counter and FSM update on the same edge. No feedback lag, because outputs decode registered state and current cnt_q.
//  IDLE: start=1 -> latch mode/limit. Next state is RUN_DN for ONESHOT_DN, RUN_UP otherwise. start while busy/DONE ignored.
//  RUN_UP, at_tgt & ~hold & ~stop: tc<=1, then by mode:
//   ONESHOT_UP -> DONE; PINGPONG -> RUN_DN; CONT_UP stays RUN_UP and keeps counting.
//  RUN_DN, at_tgt & ~hold & ~stop: tc<=1. ONESHOT_DN -> DONE; PINGPONG -> RUN_UP.
//  DONE: done=1 for exactly one cycle, then -> IDLE.
//  tc is high the cycle after detection; otherwise 0.
//  Wrap: arithmetic is mod 2^N. If cnt_q>limit_r in RUN_UP, counting wraps through 2^N-1 -> 0 and continues up to limit_r.
//   The same wrap rule applies to CONT_UP every pass.
//  limit=0 in ONESHOT_UP with cnt_q=0: no count pulses. RUN_UP -> DONE immediately, with tc.
//   ONESHOT_DN with cnt_q=0 behaves the same way.
//  hold: cnt_en=0, state/limit_r frozen, no tc. Resumes on the cycle hold falls.
//  stop in RUN_*: cnt_en=0 that cycle, next state IDLE, no tc, no done; counter keeps its value.
//   stop beats at_tgt and hold. stop in IDLE/DONE has no effect.
//  stop and start together in IDLE: start wins.
//  rst_n low mid-run: immediate return to reset values. The counter clears through the shared reset.
// TESTING
//  1. N=4, mode=00, limit=5, q=0, pulse start -> q 0..5 on 5 edges. tc then done, 1 cycle each. busy drops. q stays 5.
//  2. mode=10, limit=3 -> q 0,1,2,3,2,1,0,1,... tc pulses after each 3 and each 0. stop -> IDLE, q frozen.
//  3. mode=11, limit=2, N=4 -> q wraps 15->0. tc pulses once per 16-count pass, after each q==2.
//  4. q=6, mode=00, limit=2 -> q 7..15,0,1,2, then DONE. Check wrap path. limit=0 at q=0 -> done with zero count pulses.
//  5. hold 3 cycles mid-run -> q and state frozen, cnt_en=0, no tc. start while busy ignored. stop+start in IDLE -> run begins.
//  6. rst_n low mid-PINGPONG -> outputs 0 asynchronously, q=0. Restart after release works; cnt_up&cnt_dn never both high.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an N-bit up/down counter: runs one-shot up/down,
// ping-pong and continuous-up sequences by driving enable/direction from cnt_q.
module counter_seq_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic         hold,
    input  logic [1:0]   mode,
    input  logic [N-1:0] limit,
    input  logic [N-1:0] cnt_q,
    output logic         cnt_en,
    output logic         cnt_up,
    output logic         cnt_dn,
    output logic         busy,
    output logic         tc,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN_UP = 2'b01,
        RUN_DN = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [1:0] MODE_ONESHOT_UP = 2'b00;
    localparam logic [1:0] MODE_ONESHOT_DN = 2'b01;
    localparam logic [1:0] MODE_PINGPONG   = 2'b10;
    localparam logic [1:0] MODE_CONT_UP    = 2'b11;

    state_t       state, state_nx;
    logic [1:0]   mode_r, mode_nx;
    logic [N-1:0] limit_r, limit_nx;
    logic [N-1:0] target;
    logic         at_tgt;
    logic         tc_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_r  <= MODE_ONESHOT_UP;
            limit_r <= '0;
            tc      <= 1'b0;
        end else begin
            state   <= state_nx;
            mode_r  <= mode_nx;
            limit_r <= limit_nx;
            tc      <= tc_nx;
        end
    end

    // Outputs decode the registered state and the live counter value, so the
    // counter and this FSM can both act on the same clock edge.
    always_comb begin
        state_nx = state;
        mode_nx  = mode_r;
        limit_nx = limit_r;
        tc_nx    = 1'b0;

        target = (state == RUN_DN) ? '0 : limit_r;
        at_tgt = (cnt_q == target);
        busy   = (state == RUN_UP) || (state == RUN_DN);
        cnt_up = (state == RUN_UP);
        cnt_dn = (state == RUN_DN);
        done   = (state == DONE);
        cnt_en = busy && !hold && !stop && (!at_tgt || (mode_r == MODE_CONT_UP));

        case (state)
            IDLE: begin
                if (start) begin
                    mode_nx  = mode;
                    limit_nx = limit;
                    state_nx = (mode == MODE_ONESHOT_DN) ? RUN_DN : RUN_UP;
                end
            end
            RUN_UP: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (!hold && at_tgt) begin
                    tc_nx = 1'b1;
                    case (mode_r)
                        MODE_PINGPONG: state_nx = RUN_DN;
                        MODE_CONT_UP:  state_nx = RUN_UP;
                        default:       state_nx = DONE;
                    endcase
                end
            end
            RUN_DN: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (!hold && at_tgt) begin
                    tc_nx    = 1'b1;
                    state_nx = (mode_r == MODE_PINGPONG) ? RUN_UP : DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Testbench for counter_seq_ctrl: a behavioural up/down counter closes the loop,
// and a per-cycle scoreboard checks q/busy/tc/done against pushed expectations.
module tb_counter_seq_ctrl;

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       tc;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, hold;
    logic [1:0] mode;
    logic [3:0] limit;
    logic [3:0] cnt_q;
    logic       cnt_en, cnt_up, cnt_dn, busy, tc, done;

    logic       preset_en;
    logic [3:0] preset_val;
    logic       sb_on;
    exp_t       expq[$];
    int         checks = 0;
    int         errors = 0;

    counter_seq_ctrl #(.N(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .hold   (hold),
        .mode   (mode),
        .limit  (limit),
        .cnt_q  (cnt_q),
        .cnt_en (cnt_en),
        .cnt_up (cnt_up),
        .cnt_dn (cnt_dn),
        .busy   (busy),
        .tc     (tc),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Stand-in for the controlled counter; preset lets a test start from any q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         cnt_q <= 4'd0;
        else if (preset_en) cnt_q <= preset_val;
        else if (cnt_en && cnt_up) cnt_q <= cnt_q + 4'd1;
        else if (cnt_en && cnt_dn) cnt_q <= cnt_q - 4'd1;
    end

    // Scoreboard: one expectation is consumed per clock while enabled.
    always begin
        exp_t e;
        exp_t obs;
        @(posedge clk);
        #1;
        if (sb_on) begin
            obs = {cnt_q, busy, tc, done};
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_underflow at %0t: got q=%0d busy=%0b tc=%0b done=%0b, no expectation",
                         $time, obs.q, obs.busy, obs.tc, obs.done);
            end else begin
                e = expq.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("[TB] FAIL trace at %0t: got q=%0d busy=%0b tc=%0b done=%0b, want q=%0d busy=%0b tc=%0b done=%0b",
                             $time, obs.q, obs.busy, obs.tc, obs.done, e.q, e.busy, e.tc, e.done);
                end
            end
            checks++;
            if (cnt_up && cnt_dn) begin
                errors++;
                $display("[TB] FAIL dir_exclusive at %0t: cnt_up=%0b cnt_dn=%0b, want not both 1", $time, cnt_up, cnt_dn);
            end
        end
    end

    task automatic push(input int q, input bit b, input bit t, input bit d);
        exp_t e;
        e.q    = 4'(q);
        e.busy = b;
        e.tc   = t;
        e.done = d;
        expq.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 2'b00; limit = 4'd0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain_check(input string name);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: %0d expectations left, want 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
        mode = 2'b00; limit = 4'd0; preset_en = 1'b0; preset_val = 4'd0; sb_on = 1'b0;
        #1;
        checks++;
        if ({cnt_en, cnt_up, cnt_dn, busy, tc, done} !== 6'b0 || cnt_q !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: en/up/dn/busy/tc/done=%b q=%0d, want 000000 q=0",
                     {cnt_en, cnt_up, cnt_dn, busy, tc, done}, cnt_q);
        end
        start = 1'b1; limit = 4'd5;
        cyc(2);
        checks++;
        if (busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_held: busy=%0b tc=%0b, want 0 0", busy, tc);
        end
        do_reset();
        cyc(1);
    endtask

    task automatic test_oneshot_up();
        do_reset();
        sb_on = 1'b1;
        mode = 2'b00; limit = 4'd5; start = 1'b1;
        push(0, 1, 0, 0);
        cyc(1);
        start = 1'b0;
        #1;
        checks++;
        if (cnt_en !== 1'b1 || cnt_up !== 1'b1 || cnt_dn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_up_drive: en/up/dn=%b, want 110", {cnt_en, cnt_up, cnt_dn});
        end
        for (int v = 1; v <= 5; v++) push(v, 1, 0, 0);
        push(5, 0, 1, 1);
        push(5, 0, 0, 0);
        push(5, 0, 0, 0);
        cyc(8);
        sb_on = 1'b0;
        drain_check("oneshot_up");
    endtask

    task automatic test_pingpong();
        do_reset();
        sb_on = 1'b1;
        mode = 2'b10; limit = 4'd3; start = 1'b1;
        push(0, 1, 0, 0);
        cyc(1);
        start = 1'b0;
        for (int v = 1; v <= 3; v++) push(v, 1, 0, 0);
        push(3, 1, 1, 0);
        for (int v = 2; v >= 0; v--) push(v, 1, 0, 0);
        push(0, 1, 1, 0);
        push(1, 1, 0, 0);
        push(2, 1, 0, 0);
        cyc(10);
        stop = 1'b1;
        push(2, 0, 0, 0);
        cyc(1);
        stop = 1'b0;
        push(2, 0, 0, 0);
        push(2, 0, 0, 0);
        cyc(2);
        sb_on = 1'b0;
        drain_check("pingpong");
    endtask

    task automatic test_cont_up();
        do_reset();
        sb_on = 1'b1;
        mode = 2'b11; limit = 4'd2; start = 1'b1;
        push(0, 1, 0, 0);
        cyc(1);
        start = 1'b0;
        push(1, 1, 0, 0);
        push(2, 1, 0, 0);
        for (int p = 0; p < 2; p++)
            for (int k = 1; k <= 16; k++) push((2 + k) % 16, 1, k == 1, 0);
        cyc(34);
        stop = 1'b1;
        #1;
        checks++;
        if (cnt_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cont_stop_en: cnt_en=%0b, want 0", cnt_en);
        end
        push(2, 0, 0, 0);
        cyc(1);
        stop = 1'b0;
        push(2, 0, 0, 0);
        cyc(1);
        sb_on = 1'b0;
        drain_check("cont_up");
    endtask

    task automatic test_wrap_and_zero();
        do_reset();
        preset_en = 1'b1; preset_val = 4'd6;
        cyc(1);
        preset_en = 1'b0;
        sb_on = 1'b1;
        mode = 2'b00; limit = 4'd2; start = 1'b1;
        push(6, 1, 0, 0);
        cyc(1);
        start = 1'b0;
        for (int v = 7; v <= 18; v++) push(v % 16, 1, 0, 0);
        push(2, 0, 1, 1);
        push(2, 0, 0, 0);
        cyc(14);
        mode = 2'b01; limit = 4'd9; start = 1'b1;
        push(2, 1, 0, 0);
        cyc(1);
        start = 1'b0;
        push(1, 1, 0, 0);
        push(0, 1, 0, 0);
        push(0, 0, 1, 1);
        push(0, 0, 0, 0);
        cyc(4);
        for (int m = 0; m < 2; m++) begin
            mode = 2'(m); limit = 4'd0; start = 1'b1;
            push(0, 1, 0, 0);
            cyc(1);
            start = 1'b0;
            #1;
            checks++;
            if (cnt_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_run_en mode=%0d: cnt_en=%0b, want 0", m, cnt_en);
            end
            push(0, 0, 1, 1);
            push(0, 0, 0, 0);
            cyc(2);
        end
        sb_on = 1'b0;
        drain_check("wrap_and_zero");
    endtask

    task automatic test_hold_and_start();
        do_reset();
        sb_on = 1'b1;
        mode = 2'b00; limit = 4'd5; start = 1'b1;
        push(0, 1, 0, 0);
        cyc(1);
        start = 1'b0;
        push(1, 1, 0, 0);
        push(2, 1, 0, 0);
        cyc(2);
        hold = 1'b1; start = 1'b1; mode = 2'b01; limit = 4'd0;
        #1;
        checks++;
        if (cnt_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_en: cnt_en=%0b, want 0", cnt_en);
        end
        for (int i = 0; i < 3; i++) push(2, 1, 0, 0);
        cyc(3);
        hold = 1'b0; start = 1'b0; mode = 2'b00; limit = 4'd5;
        for (int v = 3; v <= 5; v++) push(v, 1, 0, 0);
        cyc(3);
        hold = 1'b1;
        push(5, 1, 0, 0);
        cyc(1);
        hold = 1'b0;
        push(5, 0, 1, 1);
        push(5, 0, 0, 0);
        cyc(2);
        stop = 1'b1; start = 1'b1; mode = 2'b00; limit = 4'd7;
        push(5, 1, 0, 0);
        cyc(1);
        stop = 1'b0; start = 1'b0;
        push(6, 1, 0, 0);
        push(7, 1, 0, 0);
        push(7, 0, 1, 1);
        push(7, 0, 0, 0);
        cyc(4);
        sb_on = 1'b0;
        drain_check("hold_and_start");
    endtask

    task automatic test_async_reset();
        do_reset();
        sb_on = 1'b1;
        mode = 2'b10; limit = 4'd3; start = 1'b1;
        push(0, 1, 0, 0);
        cyc(1);
        start = 1'b0;
        for (int v = 1; v <= 3; v++) push(v, 1, 0, 0);
        push(3, 1, 1, 0);
        cyc(4);
        sb_on = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cnt_en, cnt_up, cnt_dn, busy, tc, done} !== 6'b0 || cnt_q !== 4'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: en/up/dn/busy/tc/done=%b q=%0d, want 000000 q=0",
                     {cnt_en, cnt_up, cnt_dn, busy, tc, done}, cnt_q);
        end
        rst_n = 1'b1;
        drain_check("async_reset");
        sb_on = 1'b1;
        mode = 2'b00; limit = 4'd1; start = 1'b1;
        push(0, 1, 0, 0);
        cyc(1);
        start = 1'b0;
        push(1, 1, 0, 0);
        push(1, 0, 1, 1);
        push(1, 0, 0, 0);
        cyc(3);
        sb_on = 1'b0;
        drain_check("restart");
    endtask

    initial begin
        test_reset();
        test_oneshot_up();
        test_pingpong();
        test_cont_up();
        test_wrap_and_zero();
        test_hold_and_start();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
